// File: rtl/memory_request_credit_scheduler.sv
// ============================================================================
// Module   : memory_request_credit_scheduler
// Purpose  : Pop-side sequencer for the N-to-1 memory request arbiter. Issues
//            registered pops to the arbiter output FIFO, buffers the returned
//            payloads, forwards them to the memory channel (valid/ready) and
//            throttles issue against an outstanding-request credit budget.
//            Drains and halts on command.
// Options  : define MEMORY_REQUEST_SCHEDULER_STATS_EN to add the
//            issued_count_out / stall_count_out statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_request_credit_scheduler #(
  parameter int PAYLOAD_W       = 64,
  parameter int MAX_OUTSTANDING = 16,
  parameter int POP_LATENCY     = 3,
  parameter int BUF_DEPTH       = 4,
  parameter int DRAIN_TIMEOUT   = 1024,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 enable_in,
  input  logic                 flush_in,
  input  logic                 arb_empty_in,
  output logic                 arb_rd_en_out,
  input  logic                 arb_valid_in,
  input  logic [PAYLOAD_W-1:0] arb_payload_in,
  output logic                 mem_valid_out,
  output logic [PAYLOAD_W-1:0] mem_payload_out,
  input  logic                 mem_ready_in,
  input  logic                 resp_valid_in,
  output logic [CNT_W-1:0]     outstanding_out,
  output logic [1:0]           state_out,
  output logic                 done_out,
`ifdef MEMORY_REQUEST_SCHEDULER_STATS_EN
  output logic [31:0]          issued_count_out,
  output logic [31:0]          stall_count_out,
`endif
  output logic                 error_out
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int BCNT_W = $clog2(BUF_DEPTH + 1);
  localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   rd_en_q, rd_en_d;
  logic [POP_LATENCY-1:0] slot_q, slot_d;
  logic [PAYLOAD_W-1:0]   buf_q [BUF_DEPTH];
  logic [PAYLOAD_W-1:0]   buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [BCNT_W-1:0]      buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic [DCNT_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic                   err_q, err_d;

  logic                   hs;
  logic                   accept;
  logic                   wr;
  logic                   discard;
  logic                   found;
  logic                   buf_ok;
  logic                   credit_ok;
  logic [POP_LATENCY-1:0] slot_ret;
  logic [31:0]            live;

  // Buffer, credit accounting, pop reservation and control FSM next state
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_cnt_d   = buf_cnt_q;
    out_cnt_d   = out_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    discard     = 1'b0;
    found       = 1'b0;

    hs     = (buf_cnt_q != '0) && mem_ready_in;
    accept = arb_valid_in && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    // A full buffer may still take a write when the head leaves this cycle.
    wr     = accept && ((buf_cnt_q != BCNT_W'(BUF_DEPTH)) || hs);
    if (accept && !wr) begin
      err_d = 1'b1;
    end

    // A returning packet retires the oldest outstanding reservation.
    slot_ret = slot_q;
    for (int i = POP_LATENCY - 1; i >= 0; i--) begin
      if (arb_valid_in && !found && slot_q[i]) begin
        slot_ret[i] = 1'b0;
        found       = 1'b1;
      end
    end

    // Pops that may still land in the buffer: the one on the wire now plus
    // every reservation short of the top slot. The top slot either delivers
    // this cycle (already in buf_cnt_d) or never will.
    live = 32'(rd_en_q);
    for (int i = 0; i < POP_LATENCY - 1; i++) begin
      live = live + 32'(slot_ret[i]);
    end

    // Outstanding credit: handshake adds, response releases, both cancel.
    if (hs && !resp_valid_in) begin
      if (out_cnt_q < CNT_W'(MAX_OUTSTANDING)) begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end else if (!hs && resp_valid_in) begin
      if (out_cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q - CNT_W'(1);
      end
    end

    if (wr) begin
      buf_d[wr_ptr_q] = arb_payload_in;
      wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (hs) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    buf_cnt_d = buf_cnt_q + BCNT_W'(wr) - BCNT_W'(hs);

    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_in || !enable_in) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        if ((buf_cnt_d == '0) && (slot_ret == '0) && !rd_en_q && (out_cnt_d == '0)) begin
          state_d = ST_DONE;
        end else if (drain_cnt_q == DCNT_W'(DRAIN_TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          discard = 1'b1;
        end
      end
      default: begin
        if (!enable_in) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (discard) begin
      buf_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end

    buf_ok    = (32'(buf_cnt_d) + live) < 32'(BUF_DEPTH);
    credit_ok = (32'(out_cnt_d) + 32'(buf_cnt_d) + live) < 32'(MAX_OUTSTANDING);
    rd_en_d   = (state_q == ST_RUN) && (state_d == ST_RUN) && !arb_empty_in
                && buf_ok && credit_ok;

    slot_d[0] = rd_en_q;
    for (int i = 1; i < POP_LATENCY; i++) begin
      slot_d[i] = slot_ret[i-1];
    end
    if (discard) begin
      slot_d = '0;
    end
  end

  // State, buffer and counter registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      slot_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_cnt_q   <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      slot_q      <= slot_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_cnt_q   <= buf_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      buf_q       <= buf_d;
    end
  end

`ifdef MEMORY_REQUEST_SCHEDULER_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;

  // Statistics: memory handshakes and credit-limited RUN cycles, free-running wrap
  always_comb begin
    issued_d = issued_q + 32'(hs);
    stall_d  = stall_q + 32'((state_q == ST_RUN) && !arb_empty_in && !credit_ok);
  end

  // Statistics registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_count_out = issued_q;
  assign stall_count_out  = stall_q;
`endif

  assign arb_rd_en_out   = rd_en_q;
  assign mem_valid_out   = (buf_cnt_q != '0);
  assign mem_payload_out = buf_q[rd_ptr_q];
  assign outstanding_out = out_cnt_q;
  assign state_out       = state_q;
  assign done_out        = (state_q == ST_DONE);
  assign error_out       = err_q;

endmodule

`default_nettype wire
